// File: rtl/hs_npu_axi_mem_responder_if.sv
// ---------------------------------------------------------------------------
// hs_npu_axi_mem_responder_if
// AXI4 burst channel bundle between the NPU memory master and the memory
// responder. Beats are fixed at 32 bits; size and burst-type fields are not
// carried because only 4-byte INCR bursts exist on this link.
//   master modport : drives AW/W/AR payload and valids, B/R readies
//   slave  modport : drives AW/W/AR readies, B/R payload and valids
// ---------------------------------------------------------------------------
interface hs_npu_axi_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    // write address channel
    logic                  s_awvalid;
    logic                  s_awready;
    logic [ID_WIDTH-1:0]   s_awid;
    logic [ADDR_WIDTH-1:0] s_awaddr;
    logic [7:0]            s_awlen;
    // write data channel
    logic                  s_wvalid;
    logic                  s_wready;
    logic [31:0]           s_wdata;
    logic [3:0]            s_wstrb;
    logic                  s_wlast;
    // write response channel
    logic                  s_bvalid;
    logic                  s_bready;
    logic [ID_WIDTH-1:0]   s_bid;
    logic [1:0]            s_bresp;
    // read address channel
    logic                  s_arvalid;
    logic                  s_arready;
    logic [ID_WIDTH-1:0]   s_arid;
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic [7:0]            s_arlen;
    // read data channel
    logic                  s_rvalid;
    logic                  s_rready;
    logic [ID_WIDTH-1:0]   s_rid;
    logic [31:0]           s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rlast;

    modport master (
        output s_awvalid, s_awid, s_awaddr, s_awlen,
        input  s_awready,
        output s_wvalid, s_wdata, s_wstrb, s_wlast,
        input  s_wready,
        input  s_bvalid, s_bid, s_bresp,
        output s_bready,
        output s_arvalid, s_arid, s_araddr, s_arlen,
        input  s_arready,
        input  s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
        output s_rready
    );

    modport slave (
        input  s_awvalid, s_awid, s_awaddr, s_awlen,
        output s_awready,
        input  s_wvalid, s_wdata, s_wstrb, s_wlast,
        output s_wready,
        output s_bvalid, s_bid, s_bresp,
        input  s_bready,
        input  s_arvalid, s_arid, s_araddr, s_arlen,
        output s_arready,
        output s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
        input  s_rready
    );
endinterface

// File: rtl/hs_npu_axi_mem_responder.sv
// ---------------------------------------------------------------------------
// hs_npu_axi_mem_responder
// Word-addressed AXI4 INCR burst memory serving the NPU memory master. One
// transaction is in flight at a time; a write request wins over a read
// request presented in the same cycle. Burst indices wrap modulo MEM_WORDS
// and upper address bits alias. Memory contents survive reset.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (aborts any burst, no response)
//   s   : AXI slave side (AW, W, B, AR, R channels)
// MEM_WORDS must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module hs_npu_axi_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int ID_WIDTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    hs_npu_axi_mem_responder_if.slave    s
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WRESP = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ID_WIDTH-1:0]   id_r;
    logic [IDX_W-1:0]      idx_r;
    logic [7:0]            len_r;
    logic [7:0]            beat_r;
    logic                  err_r;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic awready_s, arready_s, wready_s, bvalid_s, rvalid_s;
    logic aw_hs_s, ar_hs_s, w_hs_s, r_hs_s, last_beat_s;
    logic unused_addr_s;

    // Byte offset and aliased upper address bits carry no information here.
    assign unused_addr_s = ^{s.s_awaddr[ADDR_WIDTH-1:2+IDX_W], s.s_awaddr[1:0],
                             s.s_araddr[ADDR_WIDTH-1:2+IDX_W], s.s_araddr[1:0]};

    // Channel readies/valids decoded from state; rst masks the IDLE readies.
    always_comb begin
        awready_s   = (state_r == ST_IDLE) && !rst;
        arready_s   = (state_r == ST_IDLE) && !rst && !s.s_awvalid;
        wready_s    = (state_r == ST_WRITE);
        bvalid_s    = (state_r == ST_WRESP);
        rvalid_s    = (state_r == ST_READ);
        aw_hs_s     = awready_s && s.s_awvalid;
        ar_hs_s     = arready_s && s.s_arvalid;
        w_hs_s      = wready_s && s.s_wvalid;
        r_hs_s      = rvalid_s && s.s_rready;
        last_beat_s = (beat_r == len_r);
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (aw_hs_s) begin
                    state_nxt_s = ST_WRITE;
                end else if (ar_hs_s) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Beat count alone ends the burst; wlast only grades it.
                if (w_hs_s && last_beat_s) begin
                    state_nxt_s = ST_WRESP;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_WRESP: begin
                if (s.s_bready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRESP;
                end
            end
            ST_READ: begin
                if (r_hs_s && last_beat_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus burst context (ID, word index, beat counter, error).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            id_r    <= '0;
            idx_r   <= '0;
            len_r   <= 8'd0;
            beat_r  <= 8'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (aw_hs_s) begin
                        id_r   <= s.s_awid;
                        idx_r  <= s.s_awaddr[2 +: IDX_W];
                        len_r  <= s.s_awlen;
                        beat_r <= 8'd0;
                        err_r  <= 1'b0;
                    end else if (ar_hs_s) begin
                        id_r   <= s.s_arid;
                        idx_r  <= s.s_araddr[2 +: IDX_W];
                        len_r  <= s.s_arlen;
                        beat_r <= 8'd0;
                        err_r  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (w_hs_s) begin
                        idx_r  <= idx_r + IDX_W'(1);
                        beat_r <= beat_r + 8'd1;
                        // wlast must be high exactly on the final beat.
                        if (s.s_wlast != last_beat_s) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (r_hs_s) begin
                        idx_r  <= idx_r + IDX_W'(1);
                        beat_r <= beat_r + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Byte-enabled memory write; array is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (w_hs_s) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (s.s_wstrb[b]) begin
                    mem[idx_r][8*b +: 8] <= s.s_wdata[8*b +: 8];
                end
            end
        end
    end

    assign s.s_awready = awready_s;
    assign s.s_arready = arready_s;
    assign s.s_wready  = wready_s;
    assign s.s_bvalid  = bvalid_s;
    assign s.s_bid     = bvalid_s ? id_r : '0;
    assign s.s_bresp   = (bvalid_s && err_r) ? 2'b10 : 2'b00;
    assign s.s_rvalid  = rvalid_s;
    assign s.s_rid     = rvalid_s ? id_r : '0;
    assign s.s_rdata   = rvalid_s ? mem[idx_r] : 32'd0;
    assign s.s_rresp   = 2'b00;
    assign s.s_rlast   = rvalid_s && last_beat_s;
endmodule

// File: doc/hs_npu_axi_mem_responder.md
HS_NPU_AXI_MEM_RESPONDER -- requirements
Module: hs_npu_axi_mem_responder

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, byte-address width. DATA_WIDTH, fixed 32, beat width. MEM_WORDS, default 1024, power-of-2 word count. ID_WIDTH, default 4, transaction ID width.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset. Port list follows:
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 s_awvalid/s_awready  in/out  1  AW handshake.
REQ-006 s_awid  in  ID_WIDTH  write ID.
REQ-007 s_awaddr  in  ADDR_WIDTH  burst start byte address.
REQ-008 s_awlen  in  8  beats minus 1.
REQ-009 s_wvalid/s_wready  in/out  1  W handshake.
REQ-010 s_wdata  in  32  write data.
REQ-011 s_wstrb  in  4  byte enables.
REQ-012 s_wlast  in  1  final write beat marker.
REQ-013 s_bvalid/s_bready  out/in  1  B handshake.
REQ-014 s_bid  out  ID_WIDTH  echoed AW ID.
REQ-015 s_bresp  out  2  write response.
REQ-016 s_arvalid/s_arready  in/out  1  AR handshake.
REQ-017 s_arid  in  ID_WIDTH  read ID.
REQ-018 s_araddr  in  ADDR_WIDTH  burst start byte address.
REQ-019 s_arlen  in  8  beats minus 1.
REQ-020 s_rvalid/s_rready  out/in  1  R handshake.
REQ-021 s_rid  out  ID_WIDTH  echoed AR ID.
REQ-022 s_rdata  out  32  read data.
REQ-023 s_rresp  out  2  always OKAY (00).
REQ-024 s_rlast  out  1  final read beat marker.

Function
REQ-025 The block SHALL implement the AXI4 burst responder counterpart to the NPU memory master: INCR bursts only, 4-byte beats; size and burst-type fields are not ports.
REQ-026 The FSM SHALL have states IDLE, WRITE, WRESP and READ, with one transaction outstanding at a time.
REQ-027 In IDLE, s_awready SHALL be 1; s_arready SHALL be 1 only when s_awvalid=0, so write wins on a simultaneous request.
REQ-028 AW handshake SHALL capture the ID, word index = s_awaddr[2 +: log2(MEM_WORDS)] (upper bits alias) and beat count = s_awlen, then go to WRITE.
REQ-029 In WRITE, s_wready SHALL be 1; each W handshake writes the bytes enabled by s_wstrb at the current index, then increments the index modulo MEM_WORDS (wrap to 0).
REQ-030 WRITE SHALL end after exactly awlen+1 beats, independent of s_wlast, and go to WRESP.
REQ-031 s_bresp SHALL be SLVERR (10) if s_wlast was 1 on a non-final beat or 0 on the final beat; otherwise OKAY (00).
REQ-032 In WRESP, s_bvalid=1 and s_bid holds the captured ID; on s_bready the FSM SHALL return to IDLE, with no new AW/AR accepted that cycle.
REQ-033 AR handshake SHALL capture ID, index and count as in REQ-028 and go to READ.
REQ-034 In READ, s_rvalid SHALL be 1 from the cycle after AR handshake; s_rdata SHALL be the memory word at the current index (asynchronous array read).
REQ-035 s_rlast SHALL be 1 on beat arlen; s_rdata and s_rlast SHALL be held stable while s_rvalid=1 and s_rready=0.
REQ-036 Each R handshake SHALL advance the index with wrap and present the next beat in the next cycle (no bubbles); the handshake on the last beat SHALL return the FSM to IDLE.
REQ-037 Read latency SHALL be 1 cycle from AR handshake to first rvalid; write response SHALL appear 1 cycle after the final W handshake.

Reset
REQ-038 While rst=1, the FSM SHALL be in IDLE and all ready/valid outputs SHALL be 0; s_bresp, s_rresp, s_rdata, s_rlast, s_bid and s_rid SHALL be 0.
REQ-039 Memory contents SHALL NOT be reset.
REQ-040 Reset during a burst SHALL abort it with no B or R response; words already written SHALL persist.
REQ-041 After rst deasserts, s_awready and s_arready SHALL assert in the first cycle.

Verification
REQ-042 Write awaddr=0x10, awlen=3, data 0xA0..A3, strb=F, correct wlast -> 4 beats accepted, bvalid with bresp=00 and echoed bid; read back awaddr 0x10, arlen=3 -> rdata A0..A3, rlast only on beat 3.
REQ-043 Write 0x11223344 strb=F, then 0xFFFFFFFF strb=0101 to the same word -> read returns 0x11FF33FF.
REQ-044 Burst starting at index MEM_WORDS-1 with len=1 -> second beat wraps to index 0.
REQ-045 Simultaneous awvalid and arvalid in IDLE -> write accepted first; read accepted after B handshake; rready toggled randomly -> no data lost or duplicated.
REQ-046 awlen=2 with wlast asserted on beat 1 -> 3 beats consumed, bresp=10; rst pulsed mid-read burst -> rvalid drops, FSM in IDLE, next read correct.
